mlp_result_drain: RTL and testbench

- Downstream stage of the MLP accelerator top. Captures the accelerator's result word stream, which cannot be stalled (no ready). Each 32-bit word carries two 16-bit output elements.
- Buffers words in a FIFO and re-emits them on a valid/ready stream toward the host or bus bridge. Each beat is tagged with its pair index and a last flag.
- Tracks frame completion and flags lost or unexpected words.

---
 rtl/mlp_acc_pkg.sv | 28 ++
 rtl/mlp_result_drain_if.sv | 25 ++
 rtl/sync_fifo.sv | 76 +++++++
 rtl/mlp_result_drain.sv | 122 ++++++++++++
 tb/tb_mlp_result_drain.sv | 310 +++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/mlp_acc_pkg.sv
// Shared types and constants for the MLP accelerator result path.
package mlp_acc_pkg;

  localparam int unsigned RES_W       = 32;
  localparam int unsigned ELEM_W      = 16;
  localparam int unsigned FRAME_WORDS = 128;
  localparam int unsigned IDX_W       = $clog2(FRAME_WORDS);

  // One result word carries two output elements.
  typedef struct packed {
    logic [ELEM_W-1:0] elem_even;
    logic [ELEM_W-1:0] elem_odd;
  } res_word_t;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COLLECT = 2'd1,
    DRAIN   = 2'd2
  } drain_state_e;

  // Buffered beat: frame-final flag, pair index, result word.
  typedef struct packed {
    logic             last;
    logic [IDX_W-1:0] idx;
    res_word_t        data;
  } drain_entry_t;

endpackage

// File: rtl/mlp_result_drain_if.sv
// Result capture stream (no backpressure) and buffered valid/ready output stream.
interface mlp_result_drain_if #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned IDX_W  = 7
);
  logic              res_valid_i;
  logic [DATA_W-1:0] res_payload_i;
  logic              m_valid_o;
  logic              m_ready_i;
  logic [DATA_W-1:0] m_data_o;
  logic [IDX_W-1:0]  m_idx_o;
  logic              m_last_o;

  // Drain block side: owns the output beat.
  modport master (
    input  res_valid_i, res_payload_i, m_ready_i,
    output m_valid_o, m_data_o, m_idx_o, m_last_o
  );

  // Accelerator/host side.
  modport slave (
    output res_valid_i, res_payload_i, m_ready_i,
    input  m_valid_o, m_data_o, m_idx_o, m_last_o
  );
endinterface

// File: rtl/sync_fifo.sv
// Synchronous FIFO with registered head; level counts the head register too.
module sync_fifo #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push_i,
  input  logic                     pop_i,
  input  logic                     flush_i,
  input  logic [WIDTH-1:0]         wdata_i,
  output logic [WIDTH-1:0]         rdata_o,
  output logic                     rvalid_o,
  output logic                     full_o,
  output logic [$clog2(DEPTH):0]   level_o
);

  localparam int unsigned AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW:0]      wr_ptr_q, wr_ptr_d;
  logic [AW:0]      rd_ptr_q, rd_ptr_d;
  logic [AW:0]      level_q, level_d;
  logic [WIDTH-1:0] rdata_q;
  logic             rvalid_q;
  logic             full_c, do_push_c, do_pop_c;

  // Extra pointer bit separates full from empty.
  assign full_c    = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign do_pop_c  = pop_i & rvalid_q & ~flush_i;
  assign do_push_c = push_i & ~flush_i & (~full_c | do_pop_c);

  // Pointer and level update; flush wins over push/pop.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q;
    if (flush_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      level_d  = '0;
    end else begin
      if (do_push_c) wr_ptr_d = wr_ptr_q + (AW+1)'(1);
      if (do_pop_c)  rd_ptr_d = rd_ptr_q + (AW+1)'(1);
      level_d = level_q + (AW+1)'(do_push_c) - (AW+1)'(do_pop_c);
    end
  end

  // Storage write; a slot under the head is never overwritten while it is held.
  always_ff @(posedge clk) begin
    if (do_push_c) mem_q[wr_ptr_q[AW-1:0]] <= wdata_i;
  end

  // Pointers and head register; a word written this edge shows up one edge later.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
      rvalid_q <= 1'b0;
      rdata_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
      rvalid_q <= ~flush_i && (rd_ptr_d != wr_ptr_q);
      rdata_q  <= mem_q[rd_ptr_d[AW-1:0]];
    end
  end

  assign rdata_o  = rdata_q;
  assign rvalid_o = rvalid_q;
  assign full_o   = full_c;
  assign level_o  = level_q;

endmodule

// File: rtl/mlp_result_drain.sv
// Captures the unstallable result stream, buffers it and re-emits indexed beats.
module mlp_result_drain #(
  parameter int unsigned FRAME_WORDS = 128,
  parameter int unsigned FIFO_DEPTH  = 32,
  parameter int unsigned DATA_W      = 32
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          frame_start_i,
  mlp_result_drain_if.master            bus,
  output logic                          frame_done_o,
  output logic                          overflow_o,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level_o,
  output logic                          busy_o
);
  import mlp_acc_pkg::*;

  localparam int unsigned IDX_W   = $clog2(FRAME_WORDS);
  localparam int unsigned LVL_W   = $clog2(FIFO_DEPTH) + 1;
  localparam int unsigned ENTRY_W = 1 + IDX_W + DATA_W;

  typedef struct packed {
    logic              last;
    logic [IDX_W-1:0]  idx;
    logic [DATA_W-1:0] data;
  } entry_t;

  drain_state_e     state_q, state_d;
  logic [IDX_W-1:0] in_cnt_q, in_cnt_d;
  logic             overflow_q, overflow_d;
  logic             done_q, busy_q;
  logic             push_c, drop_c, hs_c, last_in_c;
  entry_t           wr_entry, rd_entry;
  logic             fifo_full, fifo_rvalid;
  logic [LVL_W-1:0] fifo_level;

  assign hs_c      = fifo_rvalid & bus.m_ready_i;
  assign last_in_c = (in_cnt_q == IDX_W'(FRAME_WORDS - 1));
  assign wr_entry  = '{last: last_in_c, idx: in_cnt_q, data: bus.res_payload_i};

  sync_fifo #(
    .WIDTH (ENTRY_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk      (clk),
    .rst_n    (rst_n),
    .push_i   (push_c),
    .pop_i    (bus.m_ready_i),
    .flush_i  (frame_start_i),
    .wdata_i  (wr_entry),
    .rdata_o  (rd_entry),
    .rvalid_o (fifo_rvalid),
    .full_o   (fifo_full),
    .level_o  (fifo_level)
  );

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Next state; frame_start restarts collection from any state.
  always_comb begin
    state_d = state_q;
    if (frame_start_i) begin
      state_d = COLLECT;
    end else begin
      case (state_q)
        IDLE:    state_d = IDLE;
        COLLECT: if (push_c && last_in_c)   state_d = DRAIN;
        DRAIN:   if (hs_c && rd_entry.last) state_d = IDLE;
        default: state_d = IDLE;
      endcase
    end
  end

  // Write-path control: accept, drop, index advance and sticky error.
  always_comb begin
    push_c     = 1'b0;
    drop_c     = 1'b0;
    in_cnt_d   = in_cnt_q;
    overflow_d = overflow_q;
    if (frame_start_i) begin
      in_cnt_d   = '0;
      overflow_d = 1'b0;
    end else if (bus.res_valid_i) begin
      if (state_q == COLLECT && (!fifo_full || hs_c)) begin
        push_c = 1'b1;
        if (!last_in_c) in_cnt_d = in_cnt_q + IDX_W'(1);
      end else begin
        drop_c = 1'b1;
      end
      if (drop_c) overflow_d = 1'b1;
    end
  end

  // Counters, error flag and registered status outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      in_cnt_q   <= '0;
      overflow_q <= 1'b0;
      done_q     <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      in_cnt_q   <= in_cnt_d;
      overflow_q <= overflow_d;
      done_q     <= ~frame_start_i & hs_c & rd_entry.last;
      busy_q     <= (state_d != IDLE);
    end
  end

  assign bus.m_valid_o = fifo_rvalid;
  assign bus.m_data_o  = rd_entry.data;
  assign bus.m_idx_o   = rd_entry.idx;
  assign bus.m_last_o  = rd_entry.last;
  assign frame_done_o  = done_q;
  assign overflow_o    = overflow_q;
  assign fifo_level_o  = fifo_level;
  assign busy_o        = busy_q;

endmodule

// File: tb/tb_mlp_result_drain.sv
// Scoreboard bench for mlp_result_drain with a cycle-level reference model.
module tb_mlp_result_drain;

  localparam int unsigned FW    = 128;
  localparam int unsigned DEPTH = 32;
  localparam int unsigned DW    = 32;
  localparam int unsigned IW    = 7;
  localparam int unsigned LW    = 6;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          frame_start = 1'b0;
  logic          frame_done, overflow, busy;
  logic [LW-1:0] level;

  mlp_result_drain_if #(.DATA_W(DW), .IDX_W(IW)) bus ();

  mlp_result_drain #(.FRAME_WORDS(FW), .FIFO_DEPTH(DEPTH), .DATA_W(DW)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .frame_start_i (frame_start),
    .bus           (bus),
    .frame_done_o  (frame_done),
    .overflow_o    (overflow),
    .fifo_level_o  (level),
    .busy_o        (busy)
  );

  always #5 clk = ~clk;

  // Reference model state: buffered words with the edge they were accepted on.
  typedef struct { int stamp; bit last; int idx; logic [31:0] data; } ment_t;
  typedef struct { bit last; int idx; logic [31:0] data; } exp_t;

  ment_t mq[$];
  exp_t  sb[$];
  int    cyc = 0;
  int    mstate = 0;           // 0 idle, 1 collecting, 2 draining
  int    m_in = 0;
  bit    m_ovf = 0, m_done = 0;

  int checks = 0, errors = 0;
  int beats = 0, dones = 0, max_lvl = 0;
  bit stall_pend = 0;
  logic [39:0] held;

  function automatic void chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, required %0h (t=%0t)", name, act, exp, $time);
    end
  endfunction

  // Model: a word is visible one edge after acceptance, poppable on the next.
  always @(posedge clk or negedge rst_n) begin
    int sz; bit pop; int st0; ment_t e; exp_t x;
    if (!rst_n) begin
      mq.delete(); sb.delete();
      mstate = 0; m_in = 0; m_ovf = 0; m_done = 0; cyc = 0;
    end else begin
      cyc++;
      sz  = mq.size();
      st0 = mstate;
      pop = bus.m_ready_i && sz > 0 && (mq[0].stamp + 2 <= cyc);
      m_done = 0;
      if (frame_start) begin
        mq.delete(); sb.delete();
        m_in = 0; m_ovf = 0; mstate = 1;
      end else begin
        if (bus.res_valid_i) begin
          if (st0 == 1 && (sz < int'(DEPTH) || pop)) begin
            e.stamp = cyc; e.last = (m_in == FW - 1); e.idx = m_in; e.data = bus.res_payload_i;
            mq.push_back(e);
            x.last = e.last; x.idx = e.idx; x.data = e.data;
            sb.push_back(x);
            if (m_in == FW - 1) mstate = 2;
            else m_in++;
          end else begin
            m_ovf = 1;
          end
        end
        if (pop) begin
          m_done = mq[0].last;
          void'(mq.pop_front());
          if (m_done) mstate = 0;
        end
      end
    end
  end

  // Monitor: compare status every cycle and each accepted beat against the scoreboard.
  always @(negedge clk) begin
    bit   exp_valid;
    exp_t x;
    exp_valid = mq.size() > 0 && (mq[0].stamp + 1 <= cyc);
    chk("m_valid", bus.m_valid_o, exp_valid);
    chk("level", level, mq.size());
    chk("overflow", overflow, m_ovf);
    chk("busy", busy, mstate != 0);
    chk("frame_done", frame_done, m_done);
    if (int'(level) > max_lvl) max_lvl = level;
    if (frame_done) dones++;
    if (rst_n && stall_pend) begin
      chk("hold_valid", bus.m_valid_o, 1'b1);
      chk("hold_beat", {bus.m_last_o, bus.m_idx_o, bus.m_data_o}, held);
    end
    stall_pend = rst_n && bus.m_valid_o && !bus.m_ready_i && !frame_start;
    held = {bus.m_last_o, bus.m_idx_o, bus.m_data_o};
    if (rst_n && bus.m_valid_o && bus.m_ready_i && !frame_start) begin
      beats++;
      if (sb.size() == 0) begin
        checks++; errors++;
        $display("FAIL beat_unexpected: got idx %0d data %0h, required no beat", bus.m_idx_o, bus.m_data_o);
      end else begin
        x = sb.pop_front();
        chk("beat_data", bus.m_data_o, x.data);
        chk("beat_idx", bus.m_idx_o, x.idx);
        chk("beat_last", bus.m_last_o, x.last);
      end
    end
  end

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic start_frame(input bit with_word);
    frame_start = 1'b1;
    bus.res_valid_i = with_word;
    bus.res_payload_i = $urandom();
    tick();
    frame_start = 1'b0;
    bus.res_valid_i = 1'b0;
  endtask

  task automatic send_words(input int n, input logic [31:0] base);
    for (int i = 0; i < n; i++) begin
      bus.res_valid_i = 1'b1;
      bus.res_payload_i = base + 32'(i);
      tick();
    end
    bus.res_valid_i = 1'b0;
  endtask

  task automatic wait_idle(input int budget);
    int n = 0;
    while (busy && n < budget) begin tick(); n++; end
    chk("wait_idle_timeout", busy, 1'b0);
    tick(); tick();
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int b0, d0, sent;
    bus.res_valid_i = 1'b0;
    bus.res_payload_i = '0;
    bus.m_ready_i = 1'b0;
    #1;
    chk("rst_m_valid", bus.m_valid_o, 1'b0);
    chk("rst_level", level, 0);
    chk("rst_busy", busy, 1'b0);
    repeat (3) tick();
    @(posedge clk); #2 rst_n = 1'b1;
    tick();

    // Nominal frame at full rate.
    bus.m_ready_i = 1'b1;
    b0 = beats; d0 = dones;
    start_frame(0);
    send_words(FW, 32'h0001_0000);
    wait_idle(300);
    chk("nom_beats", beats - b0, FW);
    chk("nom_dones", dones - d0, 1);
    chk("nom_overflow", overflow, 1'b0);

    // Backpressure for the first 40 cycles.
    bus.m_ready_i = 1'b0;
    max_lvl = 0;
    start_frame(0);
    sent = 0;
    for (int k = 0; k < 400 && mstate == 1; k++) begin
      bus.m_ready_i = (k >= 40);
      bus.res_valid_i = 1'b1;
      bus.res_payload_i = 32'h0002_0000 + 32'(k);
      tick();
      sent++;
    end
    bus.res_valid_i = 1'b0;
    chk("bp_words_sent", sent, 136);
    chk("bp_max_level", max_lvl, DEPTH);
    chk("bp_overflow", overflow, 1'b1);
    wait_idle(300);

    // Full with a simultaneous pop.
    bus.m_ready_i = 1'b0;
    start_frame(0);
    send_words(32, 32'h0003_0000);
    tick();
    chk("full_level", level, DEPTH);
    bus.m_ready_i = 1'b1;
    bus.res_valid_i = 1'b1;
    bus.res_payload_i = 32'h0003_0020;
    tick();
    bus.res_valid_i = 1'b0;
    bus.m_ready_i = 1'b0;
    chk("fullpop_level", level, DEPTH);
    chk("fullpop_overflow", overflow, 1'b0);
    bus.m_ready_i = 1'b1;
    send_words(95, 32'h0003_0021);
    wait_idle(300);

    // Stray word in IDLE.
    bus.res_valid_i = 1'b1;
    bus.res_payload_i = $urandom();
    tick();
    bus.res_valid_i = 1'b0;
    chk("stray_idle_overflow", overflow, 1'b1);
    chk("stray_idle_level", level, 0);
    chk("stray_idle_valid", bus.m_valid_o, 1'b0);

    // Stray word in DRAIN, then restart from DRAIN.
    bus.m_ready_i = 1'b1;
    start_frame(0);
    send_words(FW, $urandom());
    bus.m_ready_i = 1'b0;
    tick(); tick();
    chk("drain_valid_pre", bus.m_valid_o, 1'b1);
    bus.res_valid_i = 1'b1;
    tick();
    bus.res_valid_i = 1'b0;
    chk("stray_drain_overflow", overflow, 1'b1);
    chk("stray_drain_valid", bus.m_valid_o, 1'b1);
    start_frame(1);
    chk("restart_drain_level", level, 0);
    chk("restart_drain_valid", bus.m_valid_o, 1'b0);
    chk("restart_drain_overflow", overflow, 1'b0);

    // Restart at word 60 with entries buffered.
    bus.m_ready_i = 1'b1;
    send_words(55, 32'h0004_0000);
    bus.m_ready_i = 1'b0;
    send_words(5, 32'h0004_0037);
    chk("pre_restart_level_nonzero", level != 0, 1'b1);
    start_frame(1);
    chk("restart_level", level, 0);
    chk("restart_valid", bus.m_valid_o, 1'b0);
    chk("restart_overflow", overflow, 1'b0);
    bus.m_ready_i = 1'b1;
    send_words(FW, 32'h0005_0000);
    wait_idle(300);

    // Randomized frames with random gaps, backpressure and occasional restarts.
    for (int f = 0; f < 5; f++) begin
      int n;
      start_frame(0);
      n = 0;
      while (n < 4000) begin
        bus.res_valid_i = ($urandom_range(99) < 75);
        bus.res_payload_i = $urandom();
        bus.m_ready_i = f[0] ? ($urandom_range(99) < 85) : ($urandom_range(99) < 40);
        frame_start = ($urandom_range(999) == 0);
        tick();
        frame_start = 1'b0;
        n++;
        if (!busy) break;
      end
      bus.res_valid_i = 1'b0;
      chk("rand_frame_timeout", busy, 1'b0);
      tick();
    end

    // Async reset in the middle of DRAIN.
    bus.m_ready_i = 1'b1;
    start_frame(0);
    send_words(FW, 32'h0006_0000);
    bus.m_ready_i = 1'b0;
    tick();
    bus.res_valid_i = 1'b1;
    tick();
    bus.res_valid_i = 1'b0;
    @(posedge clk); #3 rst_n = 1'b0;
    #1;
    chk("arst_valid", bus.m_valid_o, 1'b0);
    chk("arst_data", bus.m_data_o, 0);
    chk("arst_idx", bus.m_idx_o, 0);
    chk("arst_last", bus.m_last_o, 1'b0);
    chk("arst_overflow", overflow, 1'b0);
    chk("arst_level", level, 0);
    chk("arst_busy", busy, 1'b0);
    chk("arst_done", frame_done, 1'b0);
    @(posedge clk); #2 rst_n = 1'b1;
    tick();
    bus.m_ready_i = 1'b1;
    b0 = beats;
    start_frame(0);
    send_words(FW, 32'h0007_0000);
    wait_idle(300);
    chk("post_rst_beats", beats - b0, FW);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
